mem_bank_write_queue: RTL and testbench
=======================================

Name: mem_bank_write_queue

Overview:
Write-side front end for the banked operator/channel parameter memories. It buffers register writes from the host-register decode stage in a small FIFO and drains them onto the memory write port (wea/banka/addra/dia) only in cycles where the time-slot scheduler permits writes. After reset it sweeps every bank and address with a clear value, so parameter state is deterministic without a power cycle.

Parameters:
DATA_WIDTH, 8, width of each memory word
DEPTH, 18, words per bank
NUM_BANKS, 2, number of banks
BANK_WIDTH, max(1,$clog2(NUM_BANKS)), bank index width
FIFO_DEPTH, 4, queued writes (power of two, >=2)
CLEAR_VALUE, 0, word written by the post-reset sweep
CLEAR_ON_RESET, 1, 1: sweep after reset; 0: go straight to RUN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
in_valid  in  1  host write request
in_ready  out  1  queue can accept this cycle
in_bank  in  BANK_WIDTH  target bank
in_addr  in  $clog2(DEPTH)  target word address
in_data  in  DATA_WIDTH  write data
wr_allow  in  1  scheduler permits a memory write this cycle
wea  out  1  memory write enable (registered)
banka  out  BANK_WIDTH  memory write bank (registered)
addra  out  $clog2(DEPTH)  memory write address (registered)
dia  out  DATA_WIDTH  memory write data (registered)
busy  out  1  clear sweep in progress
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
addr_err  out  1  sticky: out-of-range request dropped

Behaviour:
- State machine has two states, CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- Register values after reset: wea=0, banka=0, addra=0, dia=0, fifo_count=0, addr_err=0, sweep counters=0. busy equals 1 in CLEAR and 0 in RUN.
- Reset during any activity discards all queued entries, restarts the sweep from (0,0) and clears addr_err.
- CLEAR state:
  - in_ready=0.
  - Each cycle with wr_allow=1, the next cycle drives wea=1 with banka/addra set to the sweep counter and dia=CLEAR_VALUE.
  - The address counter advances 0..DEPTH-1, then wraps to 0 and the bank counter increments.
  - After issuing (NUM_BANKS-1, DEPTH-1), the state moves to RUN. busy falls in the same cycle that the last wea is driven.
  - wr_allow=0 stalls the sweep; no write is issued for that cycle.
- RUN state, accept:
  - in_ready = (fifo_count < FIFO_DEPTH). This is combinational from the count. A pop in the same cycle does not free space for a push while full.
  - A push happens when in_valid && in_ready at the clock edge.
  - A request with in_bank >= NUM_BANKS or in_addr >= DEPTH is accepted but not enqueued, and it sets addr_err.
- RUN state, drain:
  - A pop happens when wr_allow && fifo_count>0.
  - The popped entry appears on wea/banka/addra/dia in the next cycle with wea=1.
  - In any cycle without a pop, the next cycle has wea=0; banka/addra/dia hold their last values.
- Latency: there is no bypass. A request accepted at edge E, with wr_allow=1 continuously, gives wea=1 in the cycle after edge E+1 (2 cycles).
- Simultaneous push and pop with 0<count<FIFO_DEPTH leaves the count unchanged.
- Order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
- Writes are issued at most one per cycle. The sink memory sees a write one cycle after the wr_allow cycle, so the scheduler asserts wr_allow one cycle ahead of the write slot.

Test Plan:
- Reset sweep: NUM_BANKS=2, DEPTH=18, wr_allow=1, CLEAR_ON_RESET=1 -> 36 consecutive wea pulses covering (0,0)..(1,17) with dia=0; busy falls with the last one; in_ready then rises.
- Stalled sweep: wr_allow toggling 1,0,1,0 -> exactly one sweep write per allowed cycle; still 36 total and addresses contiguous.
- Queue fill/drain: in RUN with wr_allow=0, push 5 writes (bank1, addr 3..7, data 0xA0..0xA4) -> in_ready=0 after 4 and the 5th is held off; fifo_count=4. Raise wr_allow -> wea for addr 3,4,5,6 with data A0..A3 in order; then the 5th request is accepted and written.
- Simultaneous push/pop: count=2, push and pop in the same cycle -> count stays 2 and the output data is the oldest entry.
- Range error: push in_addr=18 or in_bank=2 -> in_ready=1, no wea ever issued for it, addr_err=1 and it stays 1 until reset.
- Mid-operation reset: reset with 3 entries queued -> no queued write ever appears; sweep restarts at (0,0); fifo_count=0.

Source files
------------

// File: rtl/mem_bank_write_queue.sv
// Write-side front end for banked parameter memories: queues host writes, drains them in
// scheduler-permitted slots, and sweeps every bank/address with CLEAR_VALUE after reset.

// Generic single-clock FIFO; caller never pushes when full nor pops when empty.
// Latency: read data is the head entry, combinational from the read pointer.
// Backpressure: none internal; count is exported so the caller gates push/pop.
module mem_bank_wq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push_vld) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_vld)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
endmodule

// Queues host writes and drains them to the memory write port when wr_allow is high.
// Latency: accept at edge E -> registered wea in the cycle after edge E+1; sweep write one cycle after wr_allow.
// Backpressure: in_ready low while sweeping or when the queue holds FIFO_DEPTH entries.
module mem_bank_write_queue #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    DEPTH          = 18,
  parameter int                    NUM_BANKS      = 2,
  parameter int                    BANK_WIDTH     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter int                    FIFO_DEPTH     = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BANK_WIDTH-1:0]         in_bank,
  input  logic [$clog2(DEPTH)-1:0]      in_addr,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          wr_allow,
  output logic                          wea,
  output logic [BANK_WIDTH-1:0]         banka,
  output logic [$clog2(DEPTH)-1:0]      addra,
  output logic [DATA_WIDTH-1:0]         dia,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          addr_err
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BANK_WIDTH-1:0] BANK_LAST = BANK_WIDTH'(NUM_BANKS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  typedef struct packed {
    logic [BANK_WIDTH-1:0] bank;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat;
  } wr_req_t;

  state_t                state_q, state_d;
  logic [BANK_WIDTH-1:0] sweep_bank_q;
  logic [ADDR_WIDTH-1:0] sweep_addr_q;
  logic                  sweep_last;
  logic                  sweep_vld;
  logic                  in_range;
  logic                  accept_vld;
  logic                  push_vld;
  logic                  pop_vld;
  wr_req_t               push_dat;
  wr_req_t               pop_dat;

  assign sweep_last = (sweep_bank_q == BANK_LAST) && (sweep_addr_q == ADDR_LAST);
  assign sweep_vld  = (state_q == ST_CLEAR) && wr_allow;
  assign busy       = (state_q == ST_CLEAR);

  // Full-width compares so a bank field wider than NUM_BANKS needs is still range-checked.
  assign in_range   = (32'(in_bank) < NUM_BANKS) && (32'(in_addr) < DEPTH);
  assign in_ready   = (state_q == ST_RUN) && (fifo_count < CNT_WIDTH'(FIFO_DEPTH));
  assign accept_vld = in_valid && in_ready;
  assign push_vld   = accept_vld && in_range;
  assign pop_vld    = (state_q == ST_RUN) && wr_allow && (fifo_count != '0);
  assign push_dat   = '{bank: in_bank, addr: in_addr, dat: in_data};

  mem_bank_wq_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sweep_vld && sweep_last) state_d = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wea          <= 1'b0;
      banka        <= '0;
      addra        <= '0;
      dia          <= '0;
      addr_err     <= 1'b0;
      sweep_bank_q <= '0;
      sweep_addr_q <= '0;
    end else begin
      wea      <= 1'b0;
      addr_err <= addr_err | (accept_vld && !in_range);
      if (sweep_vld) begin
        wea   <= 1'b1;
        banka <= sweep_bank_q;
        addra <= sweep_addr_q;
        dia   <= CLEAR_VALUE;
        if (sweep_addr_q == ADDR_LAST) begin
          sweep_addr_q <= '0;
          sweep_bank_q <= (sweep_bank_q == BANK_LAST) ? '0 : sweep_bank_q + 1'b1;
        end else begin
          sweep_addr_q <= sweep_addr_q + 1'b1;
        end
      end else if (pop_vld) begin
        wea   <= 1'b1;
        banka <= pop_dat.bank;
        addra <= pop_dat.addr;
        dia   <= pop_dat.dat;
      end
    end
  end
endmodule

// File: tb/tb_mem_bank_write_queue.sv
// Scoreboard bench for mem_bank_write_queue: expected memory writes are queued as stimulus is
// driven and matched against every wea pulse.
module tb_mem_bank_write_queue;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_bank;
  logic [4:0] in_addr;
  logic [7:0] in_data;
  logic       wr_allow;
  logic       wea;
  logic [0:0] banka;
  logic [4:0] addra;
  logic [7:0] dia;
  logic       busy;
  logic [2:0] fifo_count;
  logic       addr_err;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_seen  = 0;
  logic [31:0] sb[$];

  mem_bank_write_queue dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bank    (in_bank),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wr_allow   (wr_allow),
    .wea        (wea),
    .banka      (banka),
    .addra      (addra),
    .dia        (dia),
    .busy       (busy),
    .fifo_count (fifo_count),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] pack(input logic b, input logic [4:0] a, input logic [7:0] d);
    return {18'b0, b, a, d};
  endfunction

  // Every wea pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wea) begin
      wr_seen++;
      if (sb.size() == 0) chk("wr_unexpected_sb_size", 32'(sb.size()), 32'd1);
      else chk("wr_bank_addr_dat", pack(banka, addra, dia), sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic load_sweep();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 18; a++)
        sb.push_back(pack(b[0], a[4:0], 8'h00));
  endtask

  // Hold a request until accepted or the budget expires; called just after a posedge.
  task automatic send(input logic b, input logic [4:0] a, input logic [7:0] d,
                      input int max_wait, output bit ok);
    logic rdy;
    in_valid = 1'b1; in_bank = b; in_addr = a; in_data = d; ok = 1'b0;
    for (int c = 0; c < max_wait && !ok; c++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && fifo_count != 0; c++) @(negedge clk);
    chk("drain_empty", 32'(fifo_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int base;
    int n;
    logic cur;
    reset = 1'b1; in_valid = 1'b0; in_bank = '0; in_addr = '0; in_data = '0; wr_allow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_bank_addr_dat", pack(banka, addra, dia), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Continuous sweep
    load_sweep();
    base = wr_seen;
    @(posedge clk); #1 reset = 1'b0; wr_allow = 1'b1;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("sweep_busy_fell", 32'(busy), 32'd0);
    chk("sweep_last_wea", 32'(wea), 32'd1);
    chk("sweep_last_bank_addr", pack(banka, addra, 8'h00), pack(1'b1, 5'd17, 8'h00));
    chk("run_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 wr_allow = 1'b0;
    chk("sweep_total", 32'(wr_seen - base), 32'd36);

    // Fill to full with writes held off, then drain in order
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 5'(3 + i), 8'(8'hA0 + i), 4, ok);
      chk("fill_accept", 32'(ok), 32'd1);
      sb.push_back(pack(1'b1, 5'(3 + i), 8'(8'hA0 + i)));
    end
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    in_valid = 1'b1; in_bank = 1'b1; in_addr = 5'd7; in_data = 8'hA4;
    @(posedge clk);
    @(negedge clk);
    chk("held_count", 32'(fifo_count), 32'd4);
    chk("held_no_wea", 32'(wea), 32'd0);
    base = wr_seen;
    @(posedge clk); #1 wr_allow = 1'b1;
    send(1'b1, 5'd7, 8'hA4, 4, ok);
    chk("fifth_accept", 32'(ok), 32'd1);
    sb.push_back(pack(1'b1, 5'd7, 8'hA4));
    wait_drain();
    chk("fill_wr_total", 32'(wr_seen - base), 32'd5);
    wr_allow = 1'b0;

    // Simultaneous push and pop at count 2
    send(1'b0, 5'd1, 8'h11, 4, ok); sb.push_back(pack(1'b0, 5'd1, 8'h11));
    send(1'b0, 5'd2, 8'h22, 4, ok); sb.push_back(pack(1'b0, 5'd2, 8'h22));
    @(negedge clk);
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    @(posedge clk); #1;
    wr_allow = 1'b1; in_valid = 1'b1; in_bank = 1'b0; in_addr = 5'd9; in_data = 8'h33;
    @(posedge clk);
    sb.push_back(pack(1'b0, 5'd9, 8'h33));
    @(negedge clk);
    chk("pp_count_after", 32'(fifo_count), 32'd2);
    chk("pp_wea", 32'(wea), 32'd1);
    chk("pp_oldest_dat", 32'(dia), 32'h11);
    wr_allow = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 wr_allow = 1'b1;
    wait_drain();
    wr_allow = 1'b0;

    // Out-of-range address is accepted, dropped and flagged
    base = wr_seen;
    send(1'b0, 5'd18, 8'h55, 4, ok);
    chk("range_accept", 32'(ok), 32'd1);
    @(negedge clk);
    chk("range_addr_err", 32'(addr_err), 32'd1);
    chk("range_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1 wr_allow = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("range_no_wr", 32'(wr_seen - base), 32'd0);
    send(1'b1, 5'd0, 8'h66, 4, ok); sb.push_back(pack(1'b1, 5'd0, 8'h66));
    wait_drain();
    chk("range_err_sticky", 32'(addr_err), 32'd1);
    wr_allow = 1'b0;

    // Reset with three entries queued, then a stalled sweep
    for (int i = 0; i < 3; i++) send(1'b0, 5'(4 + i), 8'(8'hC0 + i), 4, ok);
    @(negedge clk);
    chk("mid_count_before", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_addr_err", 32'(addr_err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_wea", 32'(wea), 32'd0);
    load_sweep();
    reset = 1'b0;
    base = wr_seen;
    n = 0;
    while (busy && n < 200) begin
      cur = (n % 2 == 0);
      wr_allow = cur;
      @(posedge clk);
      @(negedge clk);
      chk("stall_wea", 32'(wea), 32'(cur));
      n++;
    end
    chk("stall_busy_fell", 32'(busy), 32'd0);
    @(posedge clk); #1 wr_allow = 1'b0;
    chk("stall_total", 32'(wr_seen - base), 32'd36);
    repeat (3) @(posedge clk);
    #1 chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
